// File: rtl/mem_slot_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_slot_arbiter_pkg
// Description : Slot constants shared by the memory slot arbiter and vga_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_slot_arbiter_pkg;

   // Slot counter width and number of slots in one rotation
   localparam int ACNT_W    = 3;
   localparam int NUM_SLOTS = 1 << ACNT_W;

   // Slots owned by VGA by default: 0 and 4
   localparam logic [NUM_SLOTS-1:0] VGA_SLOT_MASK_DEFAULT = 8'b0001_0001;

   // Client port indices
   localparam int CLI_CPU = 0;
   localparam int CLI_IO  = 1;

   // True when the given slot belongs to VGA under the given mask
   function automatic logic is_vga_slot(input logic [NUM_SLOTS-1:0] mask,
                                        input logic [ACNT_W-1:0]    slot);
      return mask[slot];
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_slot_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Two-way round-robin picker. When both request, the client
//               named by ptr wins; otherwise the lone requester wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
   import mem_slot_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt,
   output logic       gnt_any
);

   // One-hot grant selection; ptr breaks the tie
   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11) begin
         gnt[CLI_IO]  = ptr;
         gnt[CLI_CPU] = ~ptr;
      end else begin
         gnt = req;
      end
   end

   assign gnt_any = |req;

endmodule
`default_nettype wire

// File: rtl/mem_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_slot_arbiter
// Description : Time-division arbiter for the shared memory port. A free
//               running slot count hands VGA its slots; the remaining slots
//               are shared round-robin between the CPU and IO clients.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_slot_arbiter
   import mem_slot_arbiter_pkg::*;
#(
   parameter int                    AW            = 16,
   parameter int                    DW            = 16,
   parameter logic [NUM_SLOTS-1:0]  VGA_SLOT_MASK = VGA_SLOT_MASK_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,        // asynchronous, active low
   output logic [ACNT_W-1:0] acnt,
   input  logic [AW-1:0]     vga_addr,
   output logic [DW-1:0]     vga_data,
   input  logic [1:0]        c_req,
   input  logic [1:0]        c_we,
   input  logic [2*AW-1:0]   c_addr,
   input  logic [2*DW-1:0]   c_wdata,
   output logic [1:0]        c_ack,
   output logic [DW-1:0]     c_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata
);

   logic [ACNT_W-1:0] r_acnt;
   logic              r_rr_ptr;
   logic [1:0]        r_inflight;

   logic              w_vga_slot;
   logic [1:0]        w_eligible;
   logic [1:0]        w_gnt;
   logic              w_gnt_any;
   logic              w_gnt_idx;

   assign w_vga_slot = is_vga_slot(VGA_SLOT_MASK, r_acnt);

   // A client with an access in flight cannot be re-granted in its ack cycle;
   // VGA slots hide every client request.
   assign w_eligible = c_req & ~r_inflight & {2{~w_vga_slot}};

   rr_pick2 u_pick (
      .req     (w_eligible),
      .ptr     (r_rr_ptr),
      .gnt     (w_gnt),
      .gnt_any (w_gnt_any)
   );

   assign w_gnt_idx = w_gnt[CLI_IO];

   // Slot counter, round-robin pointer and in-flight tracking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acnt     <= '0;
         r_rr_ptr   <= 1'b0;
         r_inflight <= 2'b00;
      end else begin
         r_acnt     <= r_acnt + 1'b1;
         // An access lasts exactly one cycle, so in-flight mirrors last grant
         r_inflight <= w_gnt;
         if (w_gnt_any) begin
            r_rr_ptr <= ~w_gnt_idx;
         end
      end
   end

   // Memory port mux: VGA slot, granted client, or idle (forced idle in reset)
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (rst) begin
         if (w_vga_slot) begin
            mem_en   = 1'b1;
            mem_addr = vga_addr;
         end else if (w_gnt_any) begin
            mem_en    = 1'b1;
            mem_we    = c_we[w_gnt_idx];
            mem_addr  = w_gnt_idx ? c_addr[2*AW-1:AW]  : c_addr[AW-1:0];
            mem_wdata = w_gnt_idx ? c_wdata[2*DW-1:DW] : c_wdata[DW-1:0];
         end
      end
   end

   // The ack cycle is the cycle after the grant, i.e. the in-flight cycle
   assign acnt     = r_acnt;
   assign c_ack    = r_inflight;
   assign c_rdata  = (|r_inflight) ? mem_rdata : '0;
   assign vga_data = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_slot_arbiter
// Description : Scoreboard bench for mem_slot_arbiter with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_slot_arbiter;
   import mem_slot_arbiter_pkg::*;

   localparam int AW = 16;
   localparam int DW = 16;

   logic              clk      = 1'b0;
   logic              rst      = 1'b0;
   logic [AW-1:0]     vga_addr = 16'hFB50;
   logic [2:0]        acnt;
   logic [DW-1:0]     vga_data;
   logic [1:0]        c_req    = 2'b00;
   logic [1:0]        c_we     = 2'b00;
   logic [2*AW-1:0]   c_addr   = '0;
   logic [2*DW-1:0]   c_wdata  = '0;
   logic [1:0]        c_ack;
   logic [DW-1:0]     c_rdata;
   logic              mem_en, mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [DW-1:0]     mem_rdata = '0;

   // All-VGA instance
   logic [2:0]        ff_acnt;
   logic [DW-1:0]     ff_vga_data, ff_c_rdata, ff_mem_wdata;
   logic [1:0]        ff_c_ack;
   logic              ff_mem_en, ff_mem_we;
   logic [AW-1:0]     ff_mem_addr;
   logic [1:0]        ff_req = 2'b11;

   logic [DW-1:0]     mem [0:65535];

   int n_cmp = 0;
   int n_bad = 0;
   logic [16:0] exp_q0[$];
   logic [16:0] exp_q1[$];
   int ack_log[$];
   int ack_cnt0 = 0;
   int ack_cnt1 = 0;

   always #5 clk = ~clk;

   mem_slot_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .acnt(acnt), .vga_addr(vga_addr), .vga_data(vga_data),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_ack(c_ack), .c_rdata(c_rdata), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_slot_arbiter #(.AW(AW), .DW(DW), .VGA_SLOT_MASK(8'hFF)) dut_ff (
      .clk(clk), .rst(rst), .acnt(ff_acnt), .vga_addr(vga_addr), .vga_data(ff_vga_data),
      .c_req(ff_req), .c_we(2'b11), .c_addr(32'h0040_0050), .c_wdata(32'h1234_5678),
      .c_ack(ff_c_ack), .c_rdata(ff_c_rdata), .mem_en(ff_mem_en), .mem_we(ff_mem_we),
      .mem_addr(ff_mem_addr), .mem_wdata(ff_mem_wdata), .mem_rdata(16'h0000)
   );

   // Synchronous memory model, one-cycle read latency
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         mem_rdata <= mem[mem_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expected responses whenever the DUT acks a client
   always @(negedge clk) begin
      if (rst) begin
         if (c_ack != 2'b00) begin
            check("ack_onehot", {31'd0, (c_ack == 2'b11)}, 32'd0);
            for (int n = 0; n < 2; n++) begin
               if (c_ack[n]) begin
                  logic [16:0] e;
                  int sz;
                  ack_log.push_back(n);
                  if (n == 0) ack_cnt0++; else ack_cnt1++;
                  sz = (n == 0) ? exp_q0.size() : exp_q1.size();
                  check("ack_expected", {31'd0, (sz > 0)}, 32'd1);
                  if (sz > 0) begin
                     e = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                     if (e[16]) check("c_rdata", 32'(c_rdata), 32'(e[15:0]));
                  end
               end
            end
         end else begin
            check("c_rdata_idle", 32'(c_rdata), 32'd0);
         end
      end
   end

   task automatic wait_slot(input int s);
      bit hit = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         if (acnt == 3'(s)) begin hit = 1'b1; break; end
      end
      check("wait_slot", {31'd0, hit}, 32'd1);
   endtask

   task automatic client_txn(input int n, input logic we, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [16:0] exp);
      bit got = 1'b0;
      c_we[n] = we;
      c_addr[n*AW +: AW]  = addr;
      c_wdata[n*DW +: DW] = wdata;
      if (n == 0) exp_q0.push_back(exp); else exp_q1.push_back(exp);
      c_req[n] = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (c_ack[n]) begin got = 1'b1; break; end
      end
      check("ack_timeout", {31'd0, got}, 32'd1);
      @(posedge clk); #1;
      c_req[n] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Directed stimulus
   initial begin
      int base1;
      mem[16'h0020] = 16'hAAAA;
      mem[16'h0008] = 16'h0808;
      mem[16'hFB50] = 16'hC0DE;
      mem[16'h0030] = 16'h0000;
      mem[16'h0040] = 16'h0000;

      // 1: reset, then free-running slot count
      #50;
      check("reset_acnt", 32'(acnt), 32'd0);
      check("reset_mem_en", {31'd0, mem_en}, 32'd0);
      check("reset_ack", 32'(c_ack), 32'd0);
      #52 rst = 1'b1;
      #1 check("acnt_start", 32'(acnt), 32'd0);
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk); #1;
         check("acnt_seq", 32'(acnt), 32'(k % 8));
         @(negedge clk);
         check("vga_en", {31'd0, mem_en}, {31'd0, ((k % 8) == 0 || (k % 8) == 4)});
         if ((k % 8) == 0 || (k % 8) == 4) check("vga_addr", 32'(mem_addr), 32'h0000_FB50);
         check("idle_ack", 32'(c_ack), 32'd0);
      end

      // 2: CPU read, granted in slot 1, single ack in slot 2
      wait_slot(0);
      exp_q0.push_back({1'b1, 16'hAAAA});
      c_we[0] = 1'b0; c_addr[15:0] = 16'h0020; c_req[0] = 1'b1;
      @(negedge clk);
      check("t2_vga_slot", {15'd0, mem_en, mem_we, mem_addr}, {15'd0, 1'b1, 1'b0, 16'hFB50});
      @(posedge clk); #1;
      @(negedge clk);
      check("t2_grant", {15'd0, mem_en, mem_we, mem_addr}, {15'd0, 1'b1, 1'b0, 16'h0020});
      @(posedge clk); #1;
      check("t2_ack", 32'(c_ack), 32'd1);
      @(posedge clk); #1;
      check("t2_single", 32'(c_ack), 32'd0);
      c_req[0] = 1'b0;

      // 3: both clients continuously; grants alternate
      wait_slot(2);
      ack_log.delete();
      fork
         for (int i = 0; i < 4; i++) client_txn(0, 1'b0, 16'h0008, 16'h0000, {1'b1, 16'h0808});
         for (int i = 0; i < 4; i++) client_txn(1, 1'b1, 16'h0030, 16'h1356, 17'h0);
      join
      check("t3_acks", 32'(ack_log.size()), 32'd8);
      for (int i = 1; i < ack_log.size(); i++)
         check("t3_alternate", {31'd0, (ack_log[i] != ack_log[i-1])}, 32'd1);
      client_txn(0, 1'b0, 16'h0030, 16'h0000, {1'b1, 16'h1356});

      // 4: request arriving in a VGA slot lands in the following slot
      for (int v = 0; v < 2; v++) begin
         wait_slot(v == 0 ? 4 : 0);
         exp_q0.push_back({1'b1, 16'h0808});
         c_we[0] = 1'b0; c_addr[15:0] = 16'h0008; c_req[0] = 1'b1;
         @(negedge clk);
         check("t4_vga_hold", {15'd0, mem_en, mem_we, mem_addr}, {15'd0, 1'b1, 1'b0, 16'hFB50});
         @(posedge clk); #1;
         @(negedge clk);
         check("t4_vga_data", 32'(vga_data), 32'h0000_C0DE);
         check("t4_grant", {15'd0, mem_en, mem_we, mem_addr}, {15'd0, 1'b1, 1'b0, 16'h0008});
         @(posedge clk); #1;
         check("t4_ack", 32'(c_ack), 32'd1);
         @(posedge clk); #1;
         c_req[0] = 1'b0;
      end

      // 5: reset during the grant cycle of an IO write
      wait_slot(1);
      base1 = ack_cnt1;
      exp_q1.push_back(17'h0);
      c_we[1] = 1'b1; c_addr[31:16] = 16'h0040; c_wdata[31:16] = 16'h5555; c_req[1] = 1'b1;
      @(negedge clk);
      check("t5_grant", {15'd0, mem_en, mem_we, mem_addr}, {15'd0, 1'b1, 1'b1, 16'h0040});
      #1 rst = 1'b0;
      #1 check("t5_rst_acnt", 32'(acnt), 32'd0);
      check("t5_rst_en", {31'd0, mem_en}, 32'd0);
      @(posedge clk); #1;
      check("t5_rst_ack", 32'(c_ack), 32'd0);
      check("t5_rst_inflight", 32'(dut.r_inflight), 32'd0);
      #3 rst = 1'b1;
      begin
         bit got = 1'b0;
         for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (c_ack[1]) begin got = 1'b1; break; end
         end
         check("t5_ack_seen", {31'd0, got}, 32'd1);
      end
      @(posedge clk); #1;
      c_req[1] = 1'b0;
      repeat (8) @(posedge clk);
      #1 check("t5_once", 32'(ack_cnt1 - base1), 32'd1);
      client_txn(0, 1'b0, 16'h0040, 16'h0000, {1'b1, 16'h5555});

      // 6: all-VGA mask never serves a client
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         check("t6_no_client", {28'd0, ff_c_ack, ff_mem_we, ff_mem_en}, 32'd1);
      end

      repeat (4) @(posedge clk);
      check("exp_q_empty", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
